// File: rtl/pid_pwm_pkg.sv
// -----------------------------------------------------------------------------
// pid_pwm_pkg
// Shared definitions for the PID output stage: default widths, the
// {duty, sat} result type and the shift-and-clamp function. The testbench
// may use the same clamp function as its scoreboard model.
// DUTY_W is the widest duty/period this package supports; pid_pwm's CNT_W
// must not exceed it.
// -----------------------------------------------------------------------------
package pid_pwm_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int SHIFT_DEF = 8;
  localparam int DUTY_W    = CNT_W_DEF;

  typedef struct packed {
    logic [DUTY_W-1:0] duty;
    logic              sat;
  } pwm_sat_t;

  // Arithmetic shift of the signed control value, then clamp into [0, period].
  function automatic pwm_sat_t pwm_clamp(input logic signed [31:0] un,
                                         input logic [DUTY_W-1:0]  period,
                                         input int                 shift);
    logic signed [31:0] s;
    pwm_sat_t           r;
    s = un >>> shift;
    if (s < 32'sd0) begin
      r.duty = {DUTY_W{1'b0}};
      r.sat  = 1'b1;
    end else if ($unsigned(s) > 32'(period)) begin
      // s is non-negative here, so the unsigned compare is exact
      r.duty = period;
      r.sat  = 1'b1;
    end else begin
      r.duty = DUTY_W'($unsigned(s));
      r.sat  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_deadband.sv
// -----------------------------------------------------------------------------
// pwm_deadband
// Turns the raw PWM level into a complementary output pair with dead time.
// After every raw transition both outputs are held low for DEAD cycles, then
// the side matching raw goes high. A raw phase shorter than DEAD never
// drives its side high, so both outputs are never high together.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset (outputs low)
//   i_raw    raw PWM level (cnt < duty)
//   o_pwm    high-side output, registered
//   o_pwm_n  low-side output, registered
// -----------------------------------------------------------------------------
module pwm_deadband #(
  parameter int DEAD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_pwm,
  output logic o_pwm_n
);

  localparam int DW = (DEAD < 1) ? 1 : $clog2(DEAD + 1);

  logic          r_raw_q;
  logic [DW-1:0] r_dcnt;
  logic          w_raw_nxt;
  logic [DW-1:0] w_dcnt_nxt;
  logic          w_quiet;

  // Next-state of tracked raw level and remaining dead cycles.
  always_comb begin
    w_raw_nxt  = r_raw_q;
    w_dcnt_nxt = r_dcnt;
    if (i_raw != r_raw_q) begin
      w_raw_nxt  = i_raw;
      w_dcnt_nxt = DW'(DEAD);
    end else if (r_dcnt != {DW{1'b0}}) begin
      w_dcnt_nxt = r_dcnt - DW'(1);
    end else begin
      w_dcnt_nxt = r_dcnt;
    end
  end

  // Output is decided from next state so the dead gap is exactly DEAD cycles.
  assign w_quiet = (w_dcnt_nxt == {DW{1'b0}});

  // Dead-time state and registered output pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_raw_q <= 1'b0;
      r_dcnt  <= {DW{1'b0}};
      o_pwm   <= 1'b0;
      o_pwm_n <= 1'b0;
    end else begin
      r_raw_q <= w_raw_nxt;
      r_dcnt  <= w_dcnt_nxt;
      o_pwm   <= w_raw_nxt & w_quiet;
      o_pwm_n <= ~w_raw_nxt & w_quiet;
    end
  end

endmodule

// File: rtl/pid_pwm.sv
// -----------------------------------------------------------------------------
// pid_pwm
// Output stage for the PID controller. Each valid control sample is shifted
// right by SHIFT, clamped into [0, i_period] and held as a pending duty.
// The pending duty is copied into the shadow duty only at PWM period wraps,
// so the waveform never changes mid-period; later samples in a period
// overwrite earlier ones.
// Optional feature: define PWM_DEADBAND_EN to insert DEAD cycles of
// both-low dead time around every PWM edge (pwm_deadband sub-module).
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   i_un      signed 32-bit control value
//   i_valid   one-cycle strobe qualifying i_un
//   i_period  PWM period in cycles (0 = output held low)
//   o_duty    active (shadow) duty value
//   o_pwm     high-side PWM output, registered
//   o_pwm_n   low-side PWM output, registered
//   o_sat     last captured sample was clamped
//   o_update  one-cycle pulse when the shadow duty reloads
// -----------------------------------------------------------------------------
module pid_pwm
  import pid_pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int DEAD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      i_un,
  input  logic             i_valid,
  input  logic [CNT_W-1:0] i_period,
  output logic [CNT_W-1:0] o_duty,
  output logic             o_pwm,
  output logic             o_pwm_n,
  output logic             o_sat,
  output logic             o_update
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_per_sh;
  logic [CNT_W-1:0] r_duty_sh;
  logic [CNT_W-1:0] r_pend_duty;
  logic             r_pend;
  logic             r_sat;
  logic             r_update;

  pwm_sat_t         w_clamp;
  logic             w_wrap;
  logic             w_raw;

  assign w_clamp = pwm_clamp(i_un, DUTY_W'(i_period), SHIFT);

  // A zero shadow period wraps every cycle, which is also what makes the
  // first cycle after reset pick up i_period.
  assign w_wrap = (r_per_sh == CNT_W'(0)) || (r_cnt == (r_per_sh - CNT_W'(1)));

  assign w_raw = (r_per_sh != CNT_W'(0)) && (r_cnt < r_duty_sh);

  // Period counter, shadow registers and pending-sample capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= CNT_W'(0);
      r_per_sh    <= CNT_W'(0);
      r_duty_sh   <= CNT_W'(0);
      r_pend_duty <= CNT_W'(0);
      r_pend      <= 1'b0;
      r_sat       <= 1'b0;
      r_update    <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_cnt    <= CNT_W'(0);
        r_per_sh <= i_period;
      end else begin
        r_cnt    <= r_cnt + CNT_W'(1);
      end

      // Load uses the pending value from before this edge's capture.
      if (w_wrap && r_pend) begin
        r_duty_sh <= r_pend_duty;
        r_update  <= 1'b1;
      end else begin
        r_update  <= 1'b0;
      end

      // A new sample sets pend even on a wrap edge (set wins over clear).
      if (i_valid) begin
        r_pend      <= 1'b1;
        r_pend_duty <= CNT_W'(w_clamp.duty);
        r_sat       <= w_clamp.sat;
      end else if (w_wrap) begin
        r_pend      <= 1'b0;
      end else begin
        r_pend      <= r_pend;
      end
    end
  end

`ifdef PWM_DEADBAND_EN
  pwm_deadband #(
    .DEAD (DEAD)
  ) u_deadband (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (w_raw),
    .o_pwm   (o_pwm),
    .o_pwm_n (o_pwm_n)
  );
`else
  logic r_pwm;
  logic r_pwm_n;

  // Plain complementary outputs, both low while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm   <= 1'b0;
      r_pwm_n <= 1'b0;
    end else begin
      r_pwm   <= w_raw;
      r_pwm_n <= ~w_raw;
    end
  end

  assign o_pwm   = r_pwm;
  assign o_pwm_n = r_pwm_n;
`endif

  assign o_duty   = r_duty_sh;
  assign o_sat    = r_sat;
  assign o_update = r_update;

endmodule

// File: doc/pid_pwm.md
# pid_pwm

Downstream output stage for the PID controller. Consumes each control sample (`un`/`valid`) produced by the PID core and scales and saturates it into a duty value. It double-buffers that duty value so it only changes on PWM period boundaries, and drives a registered PWM pin pair to the actuator. All samples arriving within one period collapse to the latest one.

## Interface
- `CNT_W`, 16, width of period/duty counter
- `SHIFT`, 8, arithmetic right shift applied to `i_un` before clamping
- `DEAD`, 4, dead-band length in cycles (used only when `PWM_DEADBAND_EN` is defined)

Ports:
- `clk`  in  1  sole clock, all state updates on rising edge
- `rst`  in  1  reset: one clock, synchronous, active-high
- `i_un`  in  32  signed control value from PID core
- `i_valid`  in  1  one-cycle strobe qualifying `i_un`
- `i_period`  in  CNT_W  PWM period in cycles, unsigned
- `o_duty`  out  CNT_W  active (shadow) duty value
- `o_pwm`  out  1  PWM high-side output, registered
- `o_pwm_n`  out  1  complementary low-side output, registered
- `o_sat`  out  1  last captured sample was clamped
- `o_update`  out  1  one-cycle pulse when the shadow duty is reloaded

## Operation
- **Capture.** On `i_valid`, compute `s = $signed(i_un) >>> SHIFT` (sign-preserving).
- **Clamp.** Clamp `s` into `[0, i_period]`:
  - `s < 0` → 0
  - `s > i_period` → `i_period`
  - Either clamp sets `o_sat` = 1; otherwise `o_sat` = 0.
- **Pending register.** The result goes into `pend_duty`, and `pend` is set. `o_sat` holds until the next `i_valid`.
- **Counter.** `cnt` counts 0 … `per_sh`−1, then wraps to 0.
  - `per_sh` (shadow period) reloads from `i_period` at every wrap.
  - When `per_sh` = 0, wrap asserts every cycle and `cnt` stays at 0.
- **Shadow load at wrap.** If `pend` = 1:
  - `duty_sh <= pend_duty`
  - `pend` clears
  - `o_update` pulses for one cycle
- **Simultaneous `i_valid` and wrap.**
  - The load uses the old `pend_duty`.
  - The new sample lands in `pend_duty`.
  - `pend` stays 1, because set wins over clear.
- **Raw PWM.** `raw = (cnt < duty_sh)`.
  - `duty_sh` = 0 → constant low.
  - `duty_sh` ≥ `per_sh` → constant high.
  - `per_sh` = 0 → low.
- `o_duty` = `duty_sh`.
- **Reset** (synchronous, `rst` = 1 at the edge): `cnt`, `per_sh`, `duty_sh`, `pend_duty`, `pend` → 0. All outputs → 0, including `o_pwm_n`.
- **Reset mid-period.** Aborts the period immediately. The first period after reset samples `i_period` on the first cycle.

## Timing
- `o_pwm`/`o_pwm_n` are registered from `raw`: 1 cycle after the `cnt` compare.
- `i_valid` → `pend_duty` valid: 1 cycle.
- Sample visible on `o_pwm`: at most `per_sh` + 2 cycles after `i_valid`.
- `o_update` asserts in the cycle after the wrap edge, together with the new `o_duty`.
- No backpressure: `i_valid` may assert on every cycle; only the most recent sample is kept.

## Configuration
- **`PWM_DEADBAND_EN` defined:**
  - Both outputs are forced low for `DEAD` cycles after every `raw` transition.
  - Then the side matching `raw` goes high.
  - A `raw` phase shorter than `DEAD` never drives that side high.
  - The two outputs are never high together.
- **`PWM_DEADBAND_EN` undefined:**
  - `o_pwm_n` = registered `~raw`.
  - No dead time; the `DEAD` parameter is ignored.
  - After reset, both outputs still read 0 until the first non-reset cycle.

## Structure
- **Package `pid_pwm_pkg`:**
  - `CNT_W`/`SHIFT` defaults
  - `pwm_sat_t` struct `{duty, sat}`
  - the clamp function shared with the bench scoreboard
- **Sub-module `pwm_deadband`:**
  - `raw` in, `o_pwm`/`o_pwm_n` out, internal dead counter
  - instantiated only under `PWM_DEADBAND_EN`

## Test plan
- `i_period`=100, `i_un`=0x0000_1400 → duty 20; `o_pwm` high exactly 20 of every 100 cycles; `o_sat`=0; one `o_update` at the next wrap.
- `i_un`=0xFFFF_F000 → duty 0; `o_sat`=1; `o_pwm` constant low, `o_pwm_n` constant high (macro off).
- `i_un`=0x0001_0000 (256 > 100) → duty 100; `o_sat`=1; `o_pwm` constant high.
- Two strobes mid-period (duty 10 then 30) → a single `o_update` at the wrap; next period high for 30 cycles. Strobe coinciding with the wrap → deferred one period, `pend` remains 1.
- `i_period`=0 → `o_pwm`=0 always, `o_update` on the cycle after a strobe. `rst` pulse at `cnt`=50 → next cycle `cnt`=0, `o_duty`=0, outputs 0.
- `PWM_DEADBAND_EN`, `DEAD`=4, period 100, duty 20 → `o_pwm` high 16 cycles, `o_pwm_n` high 76 cycles, two 4-cycle both-low gaps; duty 3 → `o_pwm` never high.
